// File: rtl/cdec_bus_pkg.sv
// Shared encodings for the CDEC memory-bus sequencer: core ops, FSM states,
// access owner and the value returned when an access times out.
package cdec_bus_pkg;
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP_CORE,
    S_RESP_DBG
  } state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam int              MAX_DW    = 64;
  localparam logic [MAX_DW-1:0] ERR_RDATA = '1;
endpackage

// File: rtl/cdec_mem_bus_ctrl_if.sv
// Core, memory and debug signals of the sequencer. The controller takes the
// slave view; whoever plays core + memory + debugger takes the master view.
interface cdec_mem_bus_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [1:0]    req_rw;
  logic [AW-1:0] req_adrs;
  logic [DW-1:0] req_wdata;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic [AW-1:0] mem_adrs;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          dbg_req;
  logic [AW-1:0] dbg_adrs;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_valid;
  logic          bus_err;
  logic          err_clr;

  modport slave (
    input  req_rw, req_adrs, req_wdata, mem_rdata, mem_ready, dbg_req, dbg_adrs, err_clr,
    output core_stall, core_rdata, mem_adrs, mem_wdata, mem_wr_en, mem_rd_en,
           dbg_rdata, dbg_valid, bus_err
  );

  modport master (
    output req_rw, req_adrs, req_wdata, mem_rdata, mem_ready, dbg_req, dbg_adrs, err_clr,
    input  core_stall, core_rdata, mem_adrs, mem_wdata, mem_wr_en, mem_rd_en,
           dbg_rdata, dbg_valid, bus_err
  );
endinterface

// File: rtl/cdec_wait_timer.sv
// Wait-state down-counter and timeout up-counter for one memory access.
// Both are loaded on access start, advance only while the access runs, and saturate.
module cdec_wait_timer #(
  parameter int WAIT_CYC = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_run,
  output logic o_wait_done,
  output logic o_timed_out
);
  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    WLOAD = 4'(WAIT_CYC);
  // r_tcnt counts completed ACCESS cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
  localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT - 1);

  logic [3:0]    r_wcnt;
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wcnt <= '0;
      r_tcnt <= '0;
    end else if (i_start) begin
      r_wcnt <= WLOAD;
      r_tcnt <= '0;
    end else if (i_run) begin
      if (r_wcnt != '0) r_wcnt <= r_wcnt - 4'd1;
      if (r_tcnt != TLIM) r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign o_wait_done = (r_wcnt == '0);
  assign o_timed_out = (r_tcnt == TLIM);
endmodule

// File: rtl/cdec_mem_bus_ctrl.sv
// Memory-bus sequencer for a CDEC core: wait states, ready handshake with
// timeout, core stall, arbitrated debug read port and a sticky bus error.
module cdec_mem_bus_ctrl
  import cdec_bus_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int WAIT_CYC = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic               clock,
  input  logic               reset_N,
  cdec_mem_bus_ctrl_if.slave bus
);
  state_e        r_state, w_next;
  owner_e        r_owner;
  logic [AW-1:0] r_mem_adrs;
  logic [DW-1:0] r_mem_wdata, r_core_rdata, r_dbg_rdata, w_rdata;
  logic          r_wr_en, r_rd_en, r_bus_err;
  logic          w_core_req, w_accept_core, w_accept_dbg, w_done, w_tmo, w_set_err;
  logic          w_wait_done, w_timed_out;

  assign w_core_req = (bus.req_rw == OP_WR) || (bus.req_rw == OP_RD);

  cdec_wait_timer #(.WAIT_CYC(WAIT_CYC), .TIMEOUT(TIMEOUT)) u_timer (
    .i_clk       (clock),
    .i_rst_n     (reset_N),
    .i_start     (w_accept_core | w_accept_dbg),
    .i_run       (r_state == S_ACCESS),
    .o_wait_done (w_wait_done),
    .o_timed_out (w_timed_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept_core = 1'b0;
    w_accept_dbg  = 1'b0;
    w_done        = 1'b0;
    w_tmo         = 1'b0;
    w_set_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_core_req) begin
          w_accept_core = 1'b1;
          w_next        = S_ACCESS;
        end else if (bus.req_rw == OP_RSV) begin
          w_set_err = 1'b1;
        end else if (bus.dbg_req) begin
          w_accept_dbg = 1'b1;
          w_next       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // a completing memory wins over a timeout landing in the same cycle
        if (w_wait_done && bus.mem_ready) begin
          w_done = 1'b1;
          w_next = (r_owner == OWN_DBG) ? S_RESP_DBG : S_RESP_CORE;
        end else if (w_timed_out) begin
          w_tmo     = 1'b1;
          w_set_err = 1'b1;
          w_next    = (r_owner == OWN_DBG) ? S_RESP_DBG : S_RESP_CORE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rdata = w_done ? bus.mem_rdata : ERR_RDATA[DW-1:0];

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      r_owner      <= OWN_CORE;
      r_mem_adrs   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      if (w_accept_core) begin
        r_owner     <= OWN_CORE;
        r_mem_adrs  <= bus.req_adrs;
        r_mem_wdata <= bus.req_wdata;
        r_wr_en     <= (bus.req_rw == OP_WR);
        r_rd_en     <= (bus.req_rw == OP_RD);
      end else if (w_accept_dbg) begin
        r_owner    <= OWN_DBG;
        r_mem_adrs <= bus.dbg_adrs;
        r_rd_en    <= 1'b1;
      end else if (w_done || w_tmo) begin
        r_wr_en <= 1'b0;
        r_rd_en <= 1'b0;
        if (r_rd_en) begin
          if (r_owner == OWN_DBG) r_dbg_rdata  <= w_rdata;
          else                    r_core_rdata <= w_rdata;
        end
      end
      if (w_set_err)        r_bus_err <= 1'b1;
      else if (bus.err_clr) r_bus_err <= 1'b0;
    end
  end

  assign bus.core_stall = w_core_req && (r_state != S_RESP_CORE);
  assign bus.core_rdata = r_core_rdata;
  assign bus.mem_adrs   = r_mem_adrs;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wr_en  = r_wr_en;
  assign bus.mem_rd_en  = r_rd_en;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.dbg_valid  = (r_state == S_RESP_DBG);
  assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_cdec_mem_bus_ctrl.sv
// Directed bench: three sequencer instances (no wait / 2 waits / 16-bit wide)
// sharing clock and reset, driven cycle by cycle with hand-computed expectations.
module tb_cdec_mem_bus_ctrl;
  logic clock = 1'b0;
  logic reset_N = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clock = ~clock;

  cdec_mem_bus_ctrl_if #(.DW(8),  .AW(8))  ifa ();
  cdec_mem_bus_ctrl_if #(.DW(8),  .AW(8))  ifb ();
  cdec_mem_bus_ctrl_if #(.DW(16), .AW(12)) ifc ();

  cdec_mem_bus_ctrl #(.DW(8),  .AW(8),  .WAIT_CYC(0), .TIMEOUT(8))
    u_a (.clock(clock), .reset_N(reset_N), .bus(ifa));
  cdec_mem_bus_ctrl #(.DW(8),  .AW(8),  .WAIT_CYC(2), .TIMEOUT(255))
    u_b (.clock(clock), .reset_N(reset_N), .bus(ifb));
  cdec_mem_bus_ctrl #(.DW(16), .AW(12), .WAIT_CYC(2), .TIMEOUT(255))
    u_c (.clock(clock), .reset_N(reset_N), .bus(ifc));

  // memory contents: nibble-swapped address xor 0xC1 (0x20->C3, 0x30->C2, 0x31->D2)
  assign ifa.mem_rdata = {ifa.mem_adrs[3:0], ifa.mem_adrs[7:4]} ^ 8'hC1;
  assign ifb.mem_rdata = {ifb.mem_adrs[3:0], ifb.mem_adrs[7:4]} ^ 8'hC1;
  assign ifc.mem_rdata = {8'hA5, {ifc.mem_adrs[3:0], ifc.mem_adrs[7:4]} ^ 8'hC1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // enter the next cycle, away from the edge; inputs are set here, checks after #1
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    ifa.req_rw = 2'b00; ifa.req_adrs = '0; ifa.req_wdata = '0; ifa.mem_ready = 1'b1;
    ifa.dbg_req = 1'b0; ifa.dbg_adrs = '0; ifa.err_clr = 1'b0;
    ifb.req_rw = 2'b00; ifb.req_adrs = '0; ifb.req_wdata = '0; ifb.mem_ready = 1'b1;
    ifb.dbg_req = 1'b0; ifb.dbg_adrs = '0; ifb.err_clr = 1'b0;
    ifc.req_rw = 2'b00; ifc.req_adrs = '0; ifc.req_wdata = '0; ifc.mem_ready = 1'b1;
    ifc.dbg_req = 1'b0; ifc.dbg_adrs = '0; ifc.err_clr = 1'b0;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_stall", ifa.core_stall, 0);
    chk("rst_wr_en", ifa.mem_wr_en, 0);
    chk("rst_rd_en", ifa.mem_rd_en, 0);
    chk("rst_bus_err", ifa.bus_err, 0);
    chk("rst_core_rdata", ifa.core_rdata, 0);
    chk("rst_mem_adrs", ifa.mem_adrs, 0);
    chk("rst_dbg_valid", ifa.dbg_valid, 0);
    chk("rst_c_rdata", ifc.core_rdata, 0);
    reset_N = 1'b1;

    // test 1: write 0x5A to 0x10, no wait states
    cyc(); ifa.req_rw = 2'b01; ifa.req_adrs = 8'h10; ifa.req_wdata = 8'h5A; #1;
    chk("t1_c0_stall", ifa.core_stall, 1);
    chk("t1_c0_wr_en", ifa.mem_wr_en, 0);
    cyc(); #1;
    chk("t1_c1_wr_en", ifa.mem_wr_en, 1);
    chk("t1_c1_rd_en", ifa.mem_rd_en, 0);
    chk("t1_c1_adrs", ifa.mem_adrs, 8'h10);
    chk("t1_c1_wdata", ifa.mem_wdata, 8'h5A);
    chk("t1_c1_stall", ifa.core_stall, 1);
    cyc(); #1;
    chk("t1_c2_wr_en", ifa.mem_wr_en, 0);
    chk("t1_c2_stall", ifa.core_stall, 0);
    chk("t1_c2_rdata_held", ifa.core_rdata, 0);
    ifa.req_rw = 2'b00;
    cyc(); #1;
    chk("t1_c3_wr_en", ifa.mem_wr_en, 0);
    chk("t1_c3_stall", ifa.core_stall, 0);

    // test 2: WAIT_CYC=2 read of 0x20, 8-bit and 16-bit instances in lockstep
    cyc(); ifb.req_rw = 2'b10; ifb.req_adrs = 8'h20; ifc.req_rw = 2'b10; ifc.req_adrs = 12'h020; #1;
    chk("t2_c0_stall", ifb.core_stall, 1);
    chk("t2_c0_rd_en", ifb.mem_rd_en, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      chk($sformatf("t2_c%0d_rd_en", k), ifb.mem_rd_en, 1);
      chk($sformatf("t2_c%0d_stall", k), ifb.core_stall, 1);
      chk($sformatf("t2w_c%0d_rd_en", k), ifc.mem_rd_en, 1);
    end
    cyc(); #1;
    chk("t2_c4_rd_en", ifb.mem_rd_en, 0);
    chk("t2_c4_stall", ifb.core_stall, 0);
    chk("t2_c4_rdata", ifb.core_rdata, 8'hC3);
    chk("t2w_c4_rd_en", ifc.mem_rd_en, 0);
    chk("t2w_c4_stall", ifc.core_stall, 0);
    chk("t2w_c4_rdata", ifc.core_rdata, 16'hA5C3);
    chk("t2w_adrs", ifc.mem_adrs, 12'h020);
    ifb.req_rw = 2'b00; ifc.req_rw = 2'b00;

    // test 5: reserved op sets the error, no strobe, no stall
    cyc(); ifa.req_rw = 2'b11; #1;
    chk("t5_c0_stall", ifa.core_stall, 0);
    cyc(); #1;
    chk("t5_c1_bus_err", ifa.bus_err, 1);
    chk("t5_c1_wr_en", ifa.mem_wr_en, 0);
    chk("t5_c1_rd_en", ifa.mem_rd_en, 0);
    chk("t5_c1_stall", ifa.core_stall, 0);
    ifa.req_rw = 2'b00; ifa.err_clr = 1'b1;
    cyc(); #1;
    chk("t5_clr_bus_err", ifa.bus_err, 0);
    ifa.err_clr = 1'b0;

    // test 3: mem_ready low, TIMEOUT=8
    cyc(); ifa.mem_ready = 1'b0; ifa.req_rw = 2'b10; ifa.req_adrs = 8'h44; #1;
    chk("t3_c0_stall", ifa.core_stall, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(); #1;
      chk($sformatf("t3_c%0d_rd_en", k), ifa.mem_rd_en, 1);
      chk($sformatf("t3_c%0d_bus_err", k), ifa.bus_err, 0);
    end
    cyc(); #1;
    chk("t3_resp_rd_en", ifa.mem_rd_en, 0);
    chk("t3_resp_bus_err", ifa.bus_err, 1);
    chk("t3_resp_rdata", ifa.core_rdata, 8'hFF);
    chk("t3_resp_stall", ifa.core_stall, 0);
    ifa.req_rw = 2'b00;
    cyc(); #1;
    chk("t3_idle_bus_err", ifa.bus_err, 1);
    ifa.err_clr = 1'b1; ifa.mem_ready = 1'b1;
    cyc(); #1;
    chk("t3_clr_bus_err", ifa.bus_err, 0);
    ifa.err_clr = 1'b0;

    // test 4: debug read at 0x30, core read of 0x31 arrives one cycle later
    cyc(); ifa.dbg_req = 1'b1; ifa.dbg_adrs = 8'h30; #1;
    chk("t4_c0_stall", ifa.core_stall, 0);
    cyc(); ifa.req_rw = 2'b10; ifa.req_adrs = 8'h31; #1;
    chk("t4_c1_rd_en", ifa.mem_rd_en, 1);
    chk("t4_c1_adrs", ifa.mem_adrs, 8'h30);
    chk("t4_c1_stall", ifa.core_stall, 1);
    cyc(); #1;
    chk("t4_c2_dbg_valid", ifa.dbg_valid, 1);
    chk("t4_c2_dbg_rdata", ifa.dbg_rdata, 8'hC2);
    chk("t4_c2_stall", ifa.core_stall, 1);
    chk("t4_c2_rd_en", ifa.mem_rd_en, 0);
    ifa.dbg_req = 1'b0;
    cyc(); #1;
    chk("t4_c3_dbg_valid", ifa.dbg_valid, 0);
    chk("t4_c3_stall", ifa.core_stall, 1);
    cyc(); #1;
    chk("t4_c4_rd_en", ifa.mem_rd_en, 1);
    chk("t4_c4_adrs", ifa.mem_adrs, 8'h31);
    cyc(); #1;
    chk("t4_c5_stall", ifa.core_stall, 0);
    chk("t4_c5_rdata", ifa.core_rdata, 8'hD2);
    chk("t4_c5_dbg_rdata_held", ifa.dbg_rdata, 8'hC2);
    ifa.req_rw = 2'b00;

    // test 6: reset in the middle of a write access
    cyc(); ifa.req_rw = 2'b01; ifa.req_adrs = 8'h55; ifa.req_wdata = 8'h77; #1;
    cyc(); #1;
    chk("t6_c1_wr_en", ifa.mem_wr_en, 1);
    reset_N = 1'b0;
    cyc(); #1;
    chk("t6_rst_wr_en", ifa.mem_wr_en, 0);
    chk("t6_rst_rd_en", ifa.mem_rd_en, 0);
    chk("t6_rst_adrs", ifa.mem_adrs, 0);
    chk("t6_rst_rdata", ifa.core_rdata, 0);
    chk("t6_rst_stall_idle", ifa.core_stall, 1);
    reset_N = 1'b1; ifa.req_rw = 2'b00;
    cyc(); #1;
    chk("t6_no_resp_stall", ifa.core_stall, 0);
    chk("t6_no_resp_wr_en", ifa.mem_wr_en, 0);
    chk("t6_no_resp_dbg", ifa.dbg_valid, 0);
    chk("t6_bus_err", ifa.bus_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
